// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared widths, opcodes and FSM encoding for the execute stage
package exec_pkg;
   localparam int D_SIZE  = 32;
   localparam int OP_SIZE = 4;
   localparam int RA_SIZE = 5;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;
   localparam logic [3:0] OP_DIVU = 4'd10;
   localparam logic [3:0] OP_REMU = 4'd11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
endpackage

// File: rtl/exec_if.sv
// rtl/exec_if.sv - operation/result handshake bundle between register file, execute and writeback
interface exec_if #(
   parameter int d_size  = exec_pkg::D_SIZE,
   parameter int op_size = exec_pkg::OP_SIZE,
   parameter int ra_size = exec_pkg::RA_SIZE
);
   logic               in_valid;
   logic               in_ready;
   logic [d_size-1:0]  ex_in1;
   logic [d_size-1:0]  ex_in2;
   logic [op_size-1:0] ex_op;
   logic [ra_size-1:0] ex_dest;
   logic               out_valid;
   logic               out_ready;
   logic [d_size-1:0]  ex_result;
   logic [ra_size-1:0] ex_dest_out;
   logic               ex_zero;
   logic               ex_illegal;
   logic               busy;

   modport master (
      output in_valid, ex_in1, ex_in2, ex_op, ex_dest, out_ready,
      input  in_ready, out_valid, ex_result, ex_dest_out, ex_zero, ex_illegal, busy
   );
   modport slave (
      input  in_valid, ex_in1, ex_in2, ex_op, ex_dest, out_ready,
      output in_ready, out_valid, ex_result, ex_dest_out, ex_zero, ex_illegal, busy
   );
endinterface

// File: rtl/exec_iter_muldiv.sv
// rtl/exec_iter_muldiv.sv - one-bit-per-cycle shift-add multiplier and restoring divider
// Divider datapath only exists when EXEC_DIV_EN is defined.
module exec_iter_muldiv
   import exec_pkg::*;
#(
   parameter int d_size = D_SIZE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
`ifdef EXEC_DIV_EN
   input  logic              div_mode,
   input  logic              rem_mode,
`endif
   input  logic [d_size-1:0] op_a,
   input  logic [d_size-1:0] op_b,
   output logic              done,
   output logic [d_size-1:0] result
);
   localparam int CW = $clog2(d_size) + 1;

   logic [CW-1:0]     cnt;
   logic [d_size-1:0] acc, sreg, breg;
   logic [d_size-1:0] acc_n, sreg_n, breg_n;
`ifdef EXEC_DIV_EN
   logic              div_q, rem_q;
   logic [d_size:0]   trial;
   logic              ge;
`endif

   // acc: product or partial remainder; sreg: multiplier or dividend/quotient; breg: multiplicand or divisor
   always_comb begin
      acc_n  = acc + (sreg[0] ? breg : '0);
      sreg_n = sreg >> 1;
      breg_n = breg << 1;
      result = acc_n;
`ifdef EXEC_DIV_EN
      trial = {acc, sreg[d_size-1]};
      ge    = trial >= {1'b0, breg};
      if (div_q) begin
         acc_n  = ge ? d_size'(trial - {1'b0, breg}) : trial[d_size-1:0];
         sreg_n = {sreg[d_size-2:0], ge};
         breg_n = breg;
         result = rem_q ? acc_n : sreg_n;
      end
`endif
   end

   assign done = (cnt == CW'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         acc  <= '0;
         sreg <= '0;
         breg <= '0;
`ifdef EXEC_DIV_EN
         div_q <= 1'b0;
         rem_q <= 1'b0;
`endif
      end else if (start) begin
         cnt <= CW'(d_size);
         acc <= '0;
`ifdef EXEC_DIV_EN
         div_q <= div_mode;
         rem_q <= rem_mode;
         sreg  <= div_mode ? op_a : op_b;
         breg  <= div_mode ? op_b : op_a;
`else
         sreg <= op_b;
         breg <= op_a;
`endif
      end else if (cnt != '0) begin
         cnt  <= cnt - CW'(1);
         acc  <= acc_n;
         sreg <= sreg_n;
         breg <= breg_n;
      end
   end
endmodule

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - execute stage: inline single-cycle ALU plus iterative MUL/DIVU/REMU
// EXEC_DIV_EN builds the DIV state; otherwise DIVU/REMU decode as illegal.
module exec_unit
   import exec_pkg::*;
#(
   parameter int d_size  = D_SIZE,
   parameter int op_size = OP_SIZE,
   parameter int ra_size = RA_SIZE
) (
   input logic   clk,
   input logic   rst,
   exec_if.slave bus
);
   logic [1:0]         state;
   logic [ra_size-1:0] dest_l;
   logic               accept, is_mul, is_iter;
   logic [1:0]         iter_state;
   logic [d_size-1:0]  alu_res, iter_res;
   logic               alu_ill, iter_done;
   logic [4:0]         sh;

   assign bus.in_ready = (state == ST_IDLE) && (!bus.out_valid || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign bus.busy     = (state != ST_IDLE);
   assign bus.ex_zero  = (bus.ex_result == '0);
   assign is_mul       = (bus.ex_op == OP_MUL);
   assign sh           = bus.ex_in2[4:0];

`ifdef EXEC_DIV_EN
   logic is_div;
   assign is_div     = (bus.ex_op == OP_DIVU) || (bus.ex_op == OP_REMU);
   assign is_iter    = is_mul || is_div;
   assign iter_state = is_mul ? ST_MUL : ST_DIV;
`else
   assign is_iter    = is_mul;
   assign iter_state = ST_MUL;
`endif

   // Iterative opcodes fall into the default arm too, but their ALU result is never used
   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (bus.ex_op)
         OP_ADD:  alu_res = bus.ex_in1 + bus.ex_in2;
         OP_SUB:  alu_res = bus.ex_in1 - bus.ex_in2;
         OP_AND:  alu_res = bus.ex_in1 & bus.ex_in2;
         OP_OR:   alu_res = bus.ex_in1 | bus.ex_in2;
         OP_XOR:  alu_res = bus.ex_in1 ^ bus.ex_in2;
         OP_SLT:  alu_res = d_size'($signed(bus.ex_in1) < $signed(bus.ex_in2));
         OP_SLL:  alu_res = bus.ex_in1 << sh;
         OP_SRL:  alu_res = bus.ex_in1 >> sh;
         OP_SRA:  alu_res = $unsigned($signed(bus.ex_in1) >>> sh);
         default: alu_ill = 1'b1;
      endcase
   end

   exec_iter_muldiv #(.d_size(d_size)) u_iter (
      .clk      (clk),
      .rst      (rst),
      .start    (accept && is_iter),
`ifdef EXEC_DIV_EN
      .div_mode (is_div),
      .rem_mode (bus.ex_op == OP_REMU),
`endif
      .op_a     (bus.ex_in1),
      .op_b     (bus.ex_in2),
      .done     (iter_done),
      .result   (iter_res)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= ST_IDLE;
         dest_l          <= '0;
         bus.out_valid   <= 1'b0;
         bus.ex_result   <= '0;
         bus.ex_dest_out <= '0;
         bus.ex_illegal  <= 1'b0;
      end else begin
         if (bus.out_valid && bus.out_ready)
            bus.out_valid <= 1'b0;
         if (accept) begin
            if (is_iter) begin
               state  <= iter_state;
               dest_l <= bus.ex_dest;
            end else begin
               bus.out_valid   <= 1'b1;
               bus.ex_result   <= alu_res;
               bus.ex_dest_out <= bus.ex_dest;
               bus.ex_illegal  <= alu_ill;
            end
         end
         // Slot was emptied at acceptance, so completion never collides with a held result
         if (state != ST_IDLE && iter_done) begin
            state           <= ST_IDLE;
            bus.out_valid   <= 1'b1;
            bus.ex_result   <= iter_res;
            bus.ex_dest_out <= dest_l;
            bus.ex_illegal  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - directed bench for exec_unit with an arithmetic result model and scoreboard
// DIVU/REMU expectations follow EXEC_DIV_EN.
module tb_exec_unit;
   import exec_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   exec_if bus ();
   exec_unit dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [31:0] res;
      logic [4:0]  dest;
      logic        ill;
   } exp_t;

   exp_t q[$];
   exp_t cmp_e;
   exp_t me;
   int   checks = 0;
   int   errors = 0;
   int   w, cyc, bad, seen;

   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] d);
      exp_t e;
      logic [4:0] s;
      s      = b[4:0];
      e.res  = 32'd0;
      e.ill  = 1'b0;
      e.dest = d;
      case (op)
         OP_ADD:  e.res = a + b;
         OP_SUB:  e.res = a - b;
         OP_AND:  e.res = a & b;
         OP_OR:   e.res = a | b;
         OP_XOR:  e.res = a ^ b;
         OP_SLT:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLL:  e.res = a << s;
         OP_SRL:  e.res = a >> s;
         OP_SRA:  e.res = $unsigned($signed(a) >>> s);
         OP_MUL:  e.res = a * b;
`ifdef EXEC_DIV_EN
         OP_DIVU: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REMU: e.res = (b == 0) ? a : a % b;
`endif
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %h expected none", bus.ex_result);
         end else begin
            cmp_e = q.pop_front();
            chk("sb_result", bus.ex_result, cmp_e.res);
            chk("sb_dest", 32'(bus.ex_dest_out), 32'(cmp_e.dest));
            chk("sb_illegal", 32'(bus.ex_illegal), 32'(cmp_e.ill));
            chk("sb_zero", 32'(bus.ex_zero), 32'(cmp_e.res == 32'd0));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, output int waited);
      bus.in_valid = 1'b1;
      bus.ex_op    = op;
      bus.ex_in1   = a;
      bus.ex_in2   = b;
      bus.ex_dest  = d;
      waited       = 0;
      @(negedge clk);
      while (!bus.in_ready && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: got in_ready=0 after %0d cycles expected acceptance", waited);
         bus.in_valid = 1'b0;
      end else begin
         @(posedge clk);
         q.push_back(model(op, a, b, d));
         #2;
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic wait_result(output int c, output int b);
      c = 0;
      b = 0;
      @(negedge clk);
      while (!bus.out_valid && c < 100) begin
         if (!bus.busy || bus.in_ready) b++;
         c++;
         @(negedge clk);
      end
      if (!bus.out_valid) begin
         checks++;
         errors++;
         $display("FAIL result_timeout: got out_valid=0 expected 1 within 100 cycles");
      end
   endtask

   logic [3:0]  dv_op  [4] = '{OP_DIVU, OP_REMU, OP_DIVU, OP_REMU};
   logic [31:0] dv_a   [4] = '{32'd65, 32'd65, 32'd5, 32'd5};
   logic [31:0] dv_b   [4] = '{32'd8, 32'd8, 32'd0, 32'd0};
   logic [31:0] dv_exp [4] = '{32'd8, 32'd1, 32'hFFFF_FFFF, 32'd5};

   initial begin
      bus.in_valid  = 1'b0;
      bus.ex_in1    = '0;
      bus.ex_in2    = '0;
      bus.ex_op     = '0;
      bus.ex_dest   = '0;
      bus.out_ready = 1'b1;

      me = model(OP_ADD, 32'd5, 32'd6, 5'd0);              chk("model_add", me.res, 32'd11);
      me = model(OP_SRA, 32'h8000_0000, 32'd4, 5'd0);      chk("model_sra", me.res, 32'hF800_0000);
      me = model(OP_MUL, 32'hFFFF_FFFF, 32'd2, 5'd0);      chk("model_mul", me.res, 32'hFFFF_FFFE);
      me = model(4'd14, 32'd1, 32'd2, 5'd0);               chk("model_ill", 32'(me.ill), 32'd1);

      repeat (2) step();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", bus.ex_result, 32'd0);
      chk("rst_dest", 32'(bus.ex_dest_out), 32'd0);
      chk("rst_zero", 32'(bus.ex_zero), 32'd1);
      chk("rst_illegal", 32'(bus.ex_illegal), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b1;
      step();

      issue(OP_ADD, 32'd5, 32'd6, 5'd1, w);
      issue(OP_SUB, 32'd6, 32'd7, 5'd2, w);                chk("b2b_sub_wait", 32'(w), 32'd0);
      issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd3, w);        chk("b2b_slt_wait", 32'(w), 32'd0);
      issue(OP_SRA, 32'h8000_0000, 32'd4, 5'd4, w);        chk("b2b_sra_wait", 32'(w), 32'd0);
      @(negedge clk);
      chk("sra_literal", bus.ex_result, 32'hF800_0000);
      step();

      issue(OP_MUL, 32'd7, 32'd9, 5'd3, w);
      wait_result(cyc, bad);
      chk("mul_latency", 32'(cyc), 32'd32);
      chk("mul_busy_ready", 32'(bad), 32'd0);
      chk("mul_result", bus.ex_result, 32'd63);
      chk("mul_dest", 32'(bus.ex_dest_out), 32'd3);
      step();
      issue(OP_MUL, 32'hFFFF_FFFF, 32'd2, 5'd5, w);
      wait_result(cyc, bad);
      chk("mul_wrap", bus.ex_result, 32'hFFFF_FFFE);
      step();

      for (int i = 0; i < 4; i++) begin
         issue(dv_op[i], dv_a[i], dv_b[i], 5'd6, w);
         wait_result(cyc, bad);
`ifdef EXEC_DIV_EN
         chk("div_latency", 32'(cyc), 32'd32);
         chk("div_result", bus.ex_result, dv_exp[i]);
         chk("div_illegal", 32'(bus.ex_illegal), 32'd0);
`else
         chk("div_latency", 32'(cyc), 32'd0);
         chk("div_result", bus.ex_result, 32'd0 & dv_exp[i]);
         chk("div_illegal", 32'(bus.ex_illegal), 32'd1);
`endif
         step();
      end

      bus.out_ready = 1'b0;
      issue(OP_ADD, 32'd100, 32'd23, 5'd7, w);
      wait_result(cyc, bad);
      step();
      bus.in_valid = 1'b1;
      bus.ex_op    = OP_SUB;
      bus.ex_in1   = 32'd50;
      bus.ex_in2   = 32'd8;
      bus.ex_dest  = 5'd8;
      repeat (5) begin
         @(negedge clk);
         chk("bp_result", bus.ex_result, 32'd123);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      end
      step();
      bus.out_ready = 1'b1;
      issue(OP_SUB, 32'd50, 32'd8, 5'd8, w);
      chk("bp_release_wait", 32'(w), 32'd0);
      @(negedge clk);
      chk("bp_next_result", bus.ex_result, 32'd42);
      step();

      issue(4'd14, 32'd3, 32'd4, 5'd9, w);
      wait_result(cyc, bad);
      chk("ill_result", bus.ex_result, 32'd0);
      chk("ill_zero", 32'(bus.ex_zero), 32'd1);
      chk("ill_flag", 32'(bus.ex_illegal), 32'd1);
      step();
      issue(OP_ADD, 32'd1, 32'd1, 5'd10, w);
      wait_result(cyc, bad);
      chk("ill_cleared", 32'(bus.ex_illegal), 32'd0);
      step();

      issue(OP_MUL, 32'd123, 32'd456, 5'd11, w);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b0;
      q.delete();
      #1;
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      #5;
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      chk("abort_no_result", 32'(seen), 32'd0);
      step();
      issue(OP_ADD, 32'd2, 32'd3, 5'd12, w);
      wait_result(cyc, bad);
      chk("recover_result", bus.ex_result, 32'd5);

      repeat (3) step();
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
